cla_serial_alu_ctrl: RTL and testbench
======================================

# cla_serial_alu_ctrl

Multi-cycle sequencer that performs WIDTH-bit add/subtract by time-sharing one 4-bit carry look-ahead adder slice across the operand nibbles, LSB nibble first. The carry is chained between cycles in a register. Requests arrive over a valid/ready input handshake and results leave over a valid/ready output handshake. It sits between a register-file/operand source and any consumer needing wide arithmetic where only one 4-bit CLA slice is affordable.

## Interface
- WIDTH, default 16: operand/result width. Must be a multiple of 4 and at least 8. N = WIDTH/4 nibble steps.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request (high only in IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for add; borrow-in for sub.
- sub  in  1  0 = A+B+cin; 1 = A−B−cin.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB slice. For sub, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture a into opA and (sub ? ~b : b) into opB.
  - Set carry register c = cin ^ sub.
  - Clear nibble counter k=0, then go to RUN.
- RUN: one nibble per cycle.
  - Slice inputs: opA[4k+3:4k], opB[4k+3:4k], c.
  - The slice sum nibble is written into the result shift register; the slice carry-out is stored to c.
  - k increments each cycle.
  - When k==N−1, go to DONE.
- Slice logic: per-bit g=a&b and p=a^b. The carry-outs are the fully expanded look-ahead terms with no ripple. Nibble sum = p ^ carries.
- Entering DONE, register the outputs:
  - sum ← assembled result.
  - cout ← final carry.
  - ovf ← (opA[W−1] ~^ opB[W−1]) & (sum[W−1] ^ opA[W−1]), where opB is the post-inversion value.
- DONE:
  - out_valid=1.
  - sum, cout and ovf are stable.
  - in_ready=0; in_valid is ignored.
  - On out_valid&out_ready, go to IDLE.
- sum, cout and ovf change only on entry to DONE. They hold their values otherwise, including after returning to IDLE.
- Operand inputs are sampled only at the accept edge. Changes to a, b, cin or sub afterwards have no effect.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset values (async, while rst_n=0): state=IDLE, out_valid=0, busy=0, sum=0, cout=0, ovf=0, k=0, c=0. in_ready=1 during and after reset (it is decoded from state).
- Latency: if accept happens on edge t, out_valid rises after edge t+N (N RUN cycles). For WIDTH=16, that is 4 cycles.
- Minimum request period is N+2 cycles:
  - accept edge,
  - N−1 further RUN edges plus the DONE-entry edge,
  - out-accept edge returning to IDLE,
  - next accept in IDLE.
- out_ready may already be high when out_valid rises. The transfer then occurs on the first DONE edge.
- out_ready low holds DONE indefinitely. Backpressure never corrupts outputs.
- in_valid during RUN or DONE: not accepted, no state effect.
- Reset mid-RUN or mid-DONE aborts immediately. The partial result is discarded and outputs go to their reset values. The next request after release behaves normally.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Test plan
All cases use WIDTH=16.
- Add: a=0x1234, b=0x0FFF, cin=0, sub=0 → sum=0x2233, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- Carry across all nibbles: 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Also 0xFFFF+0x0000 with cin=1 → sum=0x0000, cout=1.
- Signed overflow: 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1. Also 0x8000+0x8000 → sum=0x0000, cout=1, ovf=1.
- Subtract:
  - 0x0005−0x0007, cin=0 → sum=0xFFFE, cout=0, ovf=0.
  - 0x8000−0x0001 → sum=0x7FFF, cout=1, ovf=1.
  - 0x0010−0x0001 with borrow cin=1 → sum=0x000E, cout=1.
- Backpressure and ignore:
  - Hold out_ready=0 for 10 cycles → out_valid, sum, cout and ovf stay stable; in_ready=0; a pulsed in_valid with new operands is not accepted.
  - Then raise out_ready → IDLE next cycle, and the next request completes correctly.
- Reset mid-operation: drop rst_n two cycles into RUN → out_valid=0, sum=0, in_ready=1, busy=0. After release, 0x00FF+0x0001 → 0x0100.

Source files
------------

// File: rtl/cla_serial_alu_ctrl.sv
// Serial WIDTH-bit add/subtract built on one 4-bit carry look-ahead slice.
// Nibbles are processed LSB first, one per cycle. The carry is kept in a register between cycles.
module cla_serial_alu_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_busy
);

    localparam int N  = WIDTH / 4;
    localparam int KW = $clog2(N);
    localparam logic [KW-1:0] LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [KW-1:0]    r_k;
    logic             r_c;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-5:0] r_res;

    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic             w_c1, w_c2, w_c3, w_c4;
    logic [3:0]       w_nib;
    logic [WIDTH-1:0] w_shift;
    logic             w_last;

    // Operands shift right every RUN cycle, so the current nibble always sits in bits [3:0].
    assign w_g = r_opA[3:0] & r_opB[3:0];
    assign w_p = r_opA[3:0] ^ r_opB[3:0];

    assign w_c1 = w_g[0] | (w_p[0] & r_c);
    assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_c);
    assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & r_c);
    assign w_c4 = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_c);

    assign w_nib   = w_p ^ {w_c3, w_c2, w_c1, r_c};
    assign w_shift = {w_nib, r_res};
    assign w_last  = (r_k == LAST);

    assign o_in_ready  = (r_state == IDLE);
    assign o_out_valid = (r_state == DONE);
    assign o_busy      = (r_state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_in_valid) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    if (i_out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_k    <= '0;
            r_c    <= 1'b0;
            r_opA  <= '0;
            r_opB  <= '0;
            r_res  <= '0;
            o_sum  <= '0;
            o_cout <= 1'b0;
            o_ovf  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_opA <= i_a;
                        r_opB <= i_sub ? ~i_b : i_b;
                        r_c   <= i_cin ^ i_sub;
                        r_k   <= '0;
                    end
                end
                RUN: begin
                    r_opA <= r_opA >> 4;
                    r_opB <= r_opB >> 4;
                    r_c   <= w_c4;
                    r_res <= w_shift[WIDTH-1:4];
                    // On the last nibble, bit 3 of each operand is the original MSB.
                    if (w_last) begin
                        r_k    <= '0;
                        o_sum  <= w_shift;
                        o_cout <= w_c4;
                        o_ovf  <= (r_opA[3] ~^ r_opB[3]) & (w_nib[3] ^ r_opA[3]);
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_serial_alu_ctrl.sv
// Scoreboard bench for cla_serial_alu_ctrl at WIDTH=16. It uses directed vectors.
module tb_cla_serial_alu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   passCount  = 0;
    int   totalCount = 0;
    int   popCount   = 0;
    int   cycle      = 0;
    logic prevValid  = 1'b0;

    cla_serial_alu_ctrl #(.WIDTH(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .i_cin       (cin),
        .i_sub       (sub),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_sum       (sum),
        .o_cout      (cout),
        .o_ovf       (ovf),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // The monitor checks latency when out_valid rises and compares the result at each output transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && !prevValid) begin
            if (sb.size() == 0) checkOutput("unexpected_valid", 32'd1, 32'd0);
            else checkOutput("latency", 32'(cycle - sb[0].acc), 32'd4);
        end
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sum", 32'(sum), 32'(e.s));
                checkOutput("cout", 32'(cout), 32'(e.c));
                checkOutput("ovf", 32'(ovf), 32'(e.o));
            end
            popCount++;
        end
        prevValid = out_valid;
    end

    task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                                 input logic ts, input logic [15:0] es, input logic ec,
                                 input logic eo, input bit doPush);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 32'd0, 32'd1);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        if (doPush) sb.push_back('{s: es, c: ec, o: eo, acc: cycle});
        in_valid = 1'b0;
        a = ~ta; b = ~tb; cin = ~tc; sub = ~ts;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic waitResult();
        int start;
        int n;
        start = popCount;
        n = 0;
        while (popCount == start && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (popCount == start) checkOutput("result_timeout", 32'd0, 32'd1);
        else begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_cout", 32'(cout), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        #21 rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(16'h1234, 16'h0FFF, 0, 0, 16'h2233, 0, 0, 1); waitResult();
        applyStimulus(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1); waitResult();
        applyStimulus(16'hFFFF, 16'h0000, 1, 0, 16'h0000, 1, 0, 1); waitResult();
        applyStimulus(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 1); waitResult();
        applyStimulus(16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1, 1); waitResult();
        applyStimulus(16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0, 1); waitResult();
        applyStimulus(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 1); waitResult();
        applyStimulus(16'h0010, 16'h0001, 1, 1, 16'h000E, 1, 0, 1); waitResult();

        // The result is held under backpressure, and a request pulsed during DONE is ignored.
        out_ready = 1'b0;
        applyStimulus(16'h1111, 16'h2222, 0, 0, 16'h3333, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_sum", 32'(sum), 32'h3333);
            checkOutput("bp_cout", 32'(cout), 32'd0);
            checkOutput("bp_ovf", 32'(ovf), 32'd0);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        waitResult();
        checkOutput("idle_after_bp", 32'(in_ready), 32'd1);
        applyStimulus(16'h0001, 16'h0002, 0, 0, 16'h0003, 0, 0, 1); waitResult();
        checkOutput("hold_sum_idle", 32'(sum), 32'h0003);

        // A reset asserted in the middle of RUN aborts the operation.
        applyStimulus(16'h1234, 16'h1111, 0, 0, 16'h0000, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_sum", 32'(sum), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0, 1); waitResult();

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
